// File: rtl/eth_tx_sched_if.sv
// Signal bundle between the transmit scheduler, its frame sources,
// the frame transmitter and the link-pulse generator.
interface eth_tx_sched_if #(
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] done;
   logic [2:0]       owner;
   logic             tx_start;
   logic             tx_complete;
   logic             nlp_due;
   logic             nlp_ok;
   logic             busy;
   logic             err;
   logic             err_clr;

   modport master (
      input  req, tx_complete, nlp_due, err_clr,
      output gnt, done, owner, tx_start, nlp_ok, busy, err
   );

   modport slave (
      output req, tx_complete, nlp_due, err_clr,
      input  gnt, done, owner, tx_start, nlp_ok, busy, err
   );
endinterface

// File: rtl/eth_tx_sched.sv
// Round-robin transmit scheduler: grants the frame transmitter to one source at a
// time, enforces the inter-frame gap, keeps link pulses out of frames, watches for stalls.
module eth_tx_sched #(
   parameter int N_REQ      = 2,
   parameter int IFG_CYCLES = 12,
   parameter int TIMEOUT    = 4096,
   parameter int CW         = 16
) (
   input logic          clk,
   input logic          rst,
   eth_tx_sched_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_IFG,
      S_NLP
   } state_e;

   localparam logic [CW-1:0] IFG_LAST  = CW'(IFG_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
   localparam logic [2:0]    LAST_INIT = 3'(N_REQ - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       last_q, last_d;
   logic [2:0]       owner_q, owner_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             tx_start_q, tx_start_d;
   logic             nlp_ok_q, nlp_ok_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   logic [2:0]       winner;
   logic             any_req;

   // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (bus.req[j]) begin
            winner  = 3'(j);
            any_req = 1'b1;
         end
      end
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (bus.req[j] && (j > int'(last_q))) begin
            winner = 3'(j);
         end
      end
   end

   always_comb begin
      // NOTE: every _d starts from a hold/idle value so no branch can leave one unassigned (no latches).
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      owner_d    = owner_q;
      gnt_d      = gnt_q;
      done_d     = '0;
      tx_start_d = 1'b0;
      nlp_ok_d   = nlp_ok_q;
      err_d      = bus.err_clr ? 1'b0 : err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.nlp_due) begin
               state_d  = S_NLP;
               nlp_ok_d = 1'b1;
            end else if (any_req) begin
               state_d    = S_START;
               last_d     = winner;
               owner_d    = winner;
               gnt_d      = N_REQ'(1) << winner;
               tx_start_d = 1'b1;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.tx_complete || (cnt_q == TO_LAST)) begin
               // A completion in the same cycle as the timeout is a normal end.
               if (!bus.tx_complete) err_d = 1'b1;
               done_d  = N_REQ'(1) << owner_q;
               gnt_d   = '0;
               cnt_d   = '0;
               state_d = S_IFG;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IFG: begin
            if (cnt_q == IFG_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_NLP: begin
            if (!bus.nlp_due) begin
               nlp_ok_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_IFG;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         last_q     <= LAST_INIT;
         owner_q    <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         tx_start_q <= 1'b0;
         nlp_ok_q   <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         tx_start_q <= tx_start_d;
         nlp_ok_q   <= nlp_ok_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.owner    = owner_q;
   assign bus.tx_start = tx_start_q;
   assign bus.nlp_ok   = nlp_ok_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;

endmodule
